irq_controller: RTL

Parametrised interrupt controller between peripheral interrupt sources and the CPU core's interrupt entry logic. It generalises the fixed 15-line request bus to `NUM_SOURCES` lines with per-source edge/level mode, an enable mask, pending latches, fixed priority and a request/acknowledge/end-of-interrupt handshake. It delivers one vector at a time to the CPU. Vector 0 is the reset vector, so source *i* is presented as vector *i*+1.

---
 rtl/irq_controller_pkg.sv | 15 +
 rtl/irq_priority_enc.sv | 25 ++
 rtl/irq_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/irq_controller_pkg.sv
// Shared types and helpers for the interrupt controller.
package irq_controller_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } irq_state;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module irq_priority_enc
  import irq_controller_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge/level pending, enable mask, fixed priority, req/ack/eoi handshake.
// Define IRQ_NESTING_EN to allow higher-priority sources to preempt an active handler.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int                     NUM_SOURCES = 15,
  parameter logic [NUM_SOURCES-1:0] EDGE_MASK   = '0,
  parameter int                     VEC_W       = $clog2(NUM_SOURCES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic                   cpu_int_enable,
  input  logic                   mask_wr_en,
  input  logic [NUM_SOURCES-1:0] mask_wr_data,
  input  logic                   clr_wr_en,
  input  logic [NUM_SOURCES-1:0] clr_wr_data,
  input  logic                   irq_ack,
  input  logic                   irq_eoi,
  output logic                   irq_req,
  output logic [VEC_W-1:0]       irq_vector,
  output logic [NUM_SOURCES-1:0] pending,
  output logic                   in_service
);

  localparam int SRC_W = idx_w(NUM_SOURCES);

  irq_state               state_q, state_d;
  logic [NUM_SOURCES-1:0] prev_q;
  logic [NUM_SOURCES-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic [SRC_W-1:0]       src_q, src_d;
`ifdef IRQ_NESTING_EN
  logic [NUM_SOURCES-1:0] isr_q, isr_d;
  logic                   top_found;
  logic [SRC_W-1:0]       top_idx;
`else
  logic                   isr_q, isr_d;
`endif

  logic [NUM_SOURCES-1:0] rise, pend_all, allow, eligible, ack_clr, clr_mask;
  logic                   win_found;
  logic [SRC_W-1:0]       win_idx;

  assign rise     = irq_src & ~prev_q & EDGE_MASK;
  assign pend_all = (edge_pend_q & EDGE_MASK) | (irq_src & ~EDGE_MASK);
  assign clr_mask = clr_wr_en ? clr_wr_data : '0;

`ifdef IRQ_NESTING_EN
  irq_priority_enc #(.WIDTH(NUM_SOURCES), .IDX_W(SRC_W)) u_isr_enc (
    .req   (isr_q),
    .found (top_found),
    .idx   (top_idx)
  );

  // Only sources strictly above the highest active handler may preempt it.
  always_comb begin
    allow = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      allow[i] = !top_found || (i < int'(top_idx));
    end
  end
`else
  assign allow = '1;
`endif

  assign eligible = pend_all & mask_q & allow;

  irq_priority_enc #(.WIDTH(NUM_SOURCES), .IDX_W(SRC_W)) u_req_enc (
    .req   (eligible),
    .found (win_found),
    .idx   (win_idx)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    src_d   = src_q;
    isr_d   = isr_q;
    ack_clr = '0;
    mask_d  = mask_wr_en ? mask_wr_data : mask_q;

    case (state_q)
      IRQ_IDLE: begin
        if (win_found && cpu_int_enable) begin
          state_d = IRQ_REQ;
          vec_d   = VEC_W'(win_idx) + VEC_W'(1);
          src_d   = win_idx;
        end
      end
      IRQ_REQ: begin
        if (irq_ack) begin
          state_d        = IRQ_SERVICE;
          ack_clr[src_q] = 1'b1;
`ifdef IRQ_NESTING_EN
          isr_d[src_q]   = 1'b1;
`else
          isr_d          = 1'b1;
`endif
        end
      end
      IRQ_SERVICE: begin
`ifdef IRQ_NESTING_EN
        if (irq_eoi) begin
          isr_d[top_idx] = 1'b0;
          if (isr_d == '0) state_d = IRQ_IDLE;
        end else if (win_found && cpu_int_enable) begin
          state_d = IRQ_REQ;
          vec_d   = VEC_W'(win_idx) + VEC_W'(1);
          src_d   = win_idx;
        end
`else
        if (irq_eoi) begin
          isr_d   = 1'b0;
          state_d = IRQ_IDLE;
        end
`endif
      end
      default: state_d = IRQ_IDLE;
    endcase

    // A rising edge in the same cycle as a clear keeps the bit set.
    edge_pend_d = (edge_pend_q & ~(clr_mask | ack_clr)) | rise;
  end

  // NOTE: sequential state uses non-blocking assignments only; all of it is
  // reset because a reset mid-handshake must leave no stale request behind.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IRQ_IDLE;
      prev_q      <= '0;
      edge_pend_q <= '0;
      mask_q      <= '0;
      vec_q       <= '0;
      src_q       <= '0;
      isr_q       <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      prev_q      <= irq_src;
      edge_pend_q <= edge_pend_d;
      mask_q      <= mask_d;
      vec_q       <= vec_d;
      src_q       <= src_d;
      isr_q       <= isr_d;
    end
  end

  assign irq_req    = (state_q == IRQ_REQ);
  assign irq_vector = vec_q;
  assign in_service = |isr_q;
  // Level lines pass straight through, so hold the view at zero during reset.
  assign pending    = reset_n ? pend_all : '0;

endmodule
